// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root engine.
//   state_e : FSM encoding (ST_IDLE / ST_WORK)
//   yw_of   : result width for a given operand width, (xw+1)/2
package sqrt_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WORK = 1'b1
    } state_e;

    function automatic int unsigned yw_of(input int unsigned xw);
        return (xw + 1) / 2;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One digit of the shift/subtract square-root recurrence (combinational).
//   x_i      : partial remainder
//   y_i      : partial root (shifted form)
//   m_i      : current bit-pair mask
//   x_next_c : remainder after this digit
//   y_next_c : root after this digit
module sqrt_step #(
    parameter int unsigned XE = 16
) (
    input  logic [XE-1:0] x_i,
    input  logic [XE-1:0] y_i,
    input  logic [XE-1:0] m_i,
    output logic [XE-1:0] x_next_c,
    output logic [XE-1:0] y_next_c
);

    logic [XE-1:0] b;
    logic [XE-1:0] y_sh;

    // Trial subtrahend and pre-shifted root; the root bit is set when the trial fits.
    always_comb begin
        b        = y_i | m_i;
        y_sh     = y_i >> 1;
        x_next_c = x_i;
        y_next_c = y_sh;
        if (x_i >= b) begin
            x_next_c = x_i - b;
            y_next_c = y_sh | m_i;
        end
    end

endmodule

// File: rtl/sqrt_iter_param.sv
// Multi-cycle integer square root, one result bit per clock: y = floor(sqrt(x)).
// Optional remainder output enabled by defining SQRT_REM_EN.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous reset, active-high
//   x_bi    : operand, sampled on the accepting edge
//   start_i : request, accepted only while idle
//   busy_o  : high while computing
//   done_o  : one-cycle pulse when results update
//   y_bo    : root, held until next completion
//   rem_bo  : x - y*y (SQRT_REM_EN only)
module sqrt_iter_param
    import sqrt_pkg::*;
#(
    parameter  int unsigned XW = 16,
    localparam int unsigned YW = yw_of(XW),
    localparam int unsigned XE = 2 * YW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [XW-1:0] x_bi,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [YW-1:0] y_bo
`ifdef SQRT_REM_EN
    ,
    output logic [YW:0]   rem_bo
`endif
);

    localparam int unsigned CW = (YW > 1) ? $clog2(YW) : 1;

    state_e        state_q, state_d;
    logic [XE-1:0] x_q, x_d;
    logic [XE-1:0] y_q, y_d;
    logic [XE-1:0] m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [YW-1:0] y_out_q, y_out_d;
    logic          done_q, done_d;
`ifdef SQRT_REM_EN
    logic [YW:0]   rem_q, rem_d;
`endif

    logic [XE-1:0] x_next_c;
    logic [XE-1:0] y_next_c;

    sqrt_step #(
        .XE(XE)
    ) u_step (
        .x_i     (x_q),
        .y_i     (y_q),
        .m_i     (m_q),
        .x_next_c(x_next_c),
        .y_next_c(y_next_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        y_out_d = y_out_q;
        done_d  = 1'b0;
`ifdef SQRT_REM_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WORK;
                    x_d     = XE'(x_bi);
                    y_d     = '0;
                    m_d     = XE'(1) << (XE - 2);
                    cnt_d   = CW'(YW - 1);
                end
            end
            ST_WORK: begin
                x_d   = x_next_c;
                y_d   = y_next_c;
                m_d   = m_q >> 2;
                cnt_d = cnt_q - CW'(1);
                // Final digit publishes straight from the step outputs, no extra cycle.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    y_out_d = y_next_c[YW-1:0];
                    done_d  = 1'b1;
`ifdef SQRT_REM_EN
                    rem_d   = x_next_c[YW:0];
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            y_out_q <= '0;
            done_q  <= 1'b0;
`ifdef SQRT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            y_out_q <= y_out_d;
            done_q  <= done_d;
`ifdef SQRT_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign busy_o = (state_q == ST_WORK);
    assign done_o = done_q;
    assign y_bo   = y_out_q;
`ifdef SQRT_REM_EN
    assign rem_bo = rem_q;
`endif

endmodule
